axi_lite_master: RTL



---
 rtl/axi_lite_master.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command at a time, registered AXI and response outputs.
// A per-transaction cycle budget aborts with SLVERR if the slave never answers.
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_WIDTH       = 16
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [31:0]           i_cmd_wdata,
    input  logic [3:0]            i_cmd_wstrb,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_data,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_rsp_timeout,
    output logic                  o_awvalid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    input  logic                  i_awready,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic [31:0]           o_wdata,
    output logic [3:0]            o_wstrb,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [1:0]            i_rresp,
    input  logic [31:0]           i_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_A,
        S_RD_D,
        S_RSP
    } state_t;

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        TO_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_to_q, rsp_to_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;

    logic aw_done;
    logic w_done;
    logic expire;
    logic abort;

    // A channel counts as done once its valid has dropped or handshakes now.
    assign aw_done = !awvalid_q || i_awready;
    assign w_done  = !wvalid_q || i_wready;
    assign expire  = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_to_d    = rsp_to_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        abort       = 1'b0;

        if (state_q != S_IDLE && state_q != S_RSP && cnt_q != '1) begin
            cnt_d = cnt_q + TO_WIDTH'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (i_cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = i_cmd_addr;
                    wdata_d     = i_cmd_wdata;
                    wstrb_d     = i_cmd_wstrb;
                    cnt_d       = '0;
                    if (i_cmd_rnw) begin
                        state_d   = S_RD_A;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (awvalid_q && i_awready) awvalid_d = 1'b0;
                if (wvalid_q && i_wready) wvalid_d = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = S_WR_B;
                    bready_d = 1'b1;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            S_WR_B: begin
                if (i_bvalid) begin
                    state_d     = S_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = i_bresp;
                    rsp_data_d  = '0;
                    rsp_to_d    = 1'b0;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            S_RD_A: begin
                if (i_arready) begin
                    state_d   = S_RD_D;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            S_RD_D: begin
                if (i_rvalid) begin
                    state_d     = S_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = i_rresp;
                    rsp_data_d  = i_rdata;
                    rsp_to_d    = 1'b0;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_to_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = S_RSP;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = 2'b10;
            rsp_data_d  = '0;
            rsp_to_d    = 1'b1;
        end
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_to_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_to_q    <= rsp_to_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign o_rsp_timeout = rsp_to_q;
    assign o_awvalid     = awvalid_q;
    assign o_awaddr      = addr_q;
    assign o_wvalid      = wvalid_q;
    assign o_wdata       = wdata_q;
    assign o_wstrb       = wstrb_q;
    assign o_bready      = bready_q;
    assign o_arvalid     = arvalid_q;
    assign o_araddr      = addr_q;
    assign o_rready      = rready_q;

endmodule
